// File: rtl/stage_ex.sv
`default_nettype none
// ============================================================================
// stage_ex : MIPS execute stage - ALU, iterative MUL/DIVU, EX/MEM register
// Revision : 1.0 - initial release
// ============================================================================
module stage_ex #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWriteIn,
  input  logic              memToRegIn,
  input  logic              memWriteIn,
  input  logic              branchIn,
  input  logic              aluSrc,
  input  logic              regDst,
  input  logic [3:0]        aluCtrl,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] signExtImm,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [PC_W-1:0]   inCurrentPC,
  output logic              regWriteOut,
  output logic              memToRegOut,
  output logic              memWriteOut,
  output logic              branchOut,
  output logic              zeroOut,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [DATA_W-1:0] writeDataOut,
  output logic [4:0]        wrOut,
  output logic [PC_W-1:0]   outCurrentPC,
  output logic [PC_W-1:0]   branchTarget,
  output logic              stall
);

  localparam int              CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(DATA_W - 1);

  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SLT  = 4'b0111;
  localparam logic [3:0] c_OP_NOR  = 4'b1100;
  localparam logic [3:0] c_OP_MUL  = 4'b1000;
  localparam logic [3:0] c_OP_DIVU = 4'b1001;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_count;
  logic              r_isDiv;
  logic [DATA_W-1:0] r_opA;
  logic [DATA_W-1:0] r_opB;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_rem;

  logic [DATA_W-1:0] w_opB;
  logic [DATA_W-1:0] w_aluRes;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_mulAdd;
  logic [DATA_W:0]   w_remShift;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;
  logic              w_isMulDiv;

  assign w_opB      = aluSrc ? signExtImm : readData2;
  assign w_isMulDiv = (aluCtrl == c_OP_MUL) || (aluCtrl == c_OP_DIVU);
  assign stall      = w_isMulDiv && (r_state != c_DONE) && !reset;

  always_comb begin
    w_aluRes = '0;
    case (aluCtrl)
      c_OP_AND: w_aluRes = readData1 & w_opB;
      c_OP_OR:  w_aluRes = readData1 | w_opB;
      c_OP_ADD: w_aluRes = readData1 + w_opB;
      c_OP_SUB: w_aluRes = readData1 - w_opB;
      c_OP_SLT: w_aluRes = {{(DATA_W-1){1'b0}}, ($signed(readData1) < $signed(w_opB))};
      c_OP_NOR: w_aluRes = ~(readData1 | w_opB);
      default:  w_aluRes = '0;
    endcase
  end

  // Restoring division: r_opA shifts the dividend out and the quotient in.
  // A zero divisor always "fits", which yields the all-ones quotient.
  assign w_remShift = {r_rem, r_opA[DATA_W-1]};
  assign w_diff     = w_remShift - {1'b0, r_opB};
  assign w_ge       = (w_remShift >= {1'b0, r_opB});
  assign w_mulAdd   = r_opB[0] ? r_opA : '0;

  assign w_result = (r_state == c_DONE) ? (r_isDiv ? r_opA : r_acc) : w_aluRes;

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_count <= '0;
      r_isDiv <= 1'b0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_isMulDiv) begin
            r_opA   <= readData1;
            r_opB   <= w_opB;
            r_acc   <= '0;
            r_rem   <= '0;
            r_count <= '0;
            r_isDiv <= (aluCtrl == c_OP_DIVU);
            r_state <= c_BUSY;
          end
        end
        c_BUSY: begin
          if (r_isDiv) begin
            r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_remShift[DATA_W-1:0];
            r_opA <= {r_opA[DATA_W-2:0], w_ge};
          end else begin
            r_acc <= r_acc + w_mulAdd;
            r_opA <= r_opA << 1;
            r_opB <= r_opB >> 1;
          end
          r_count <= r_count + CNT_W'(1);
          if (r_count == c_LAST_STEP) begin
            r_state <= c_DONE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      regWriteOut  <= 1'b0;
      memToRegOut  <= 1'b0;
      memWriteOut  <= 1'b0;
      branchOut    <= 1'b0;
      zeroOut      <= 1'b0;
      aluResultOut <= '0;
      writeDataOut <= '0;
      wrOut        <= '0;
      outCurrentPC <= '0;
      branchTarget <= '0;
    end else if (stall) begin
      // Bubble: zero result, so zeroOut reads 1.
      regWriteOut  <= 1'b0;
      memToRegOut  <= 1'b0;
      memWriteOut  <= 1'b0;
      branchOut    <= 1'b0;
      zeroOut      <= 1'b1;
      aluResultOut <= '0;
      writeDataOut <= '0;
      wrOut        <= '0;
      outCurrentPC <= '0;
      branchTarget <= '0;
    end else begin
      regWriteOut  <= regWriteIn;
      memToRegOut  <= memToRegIn;
      memWriteOut  <= memWriteIn;
      branchOut    <= branchIn;
      zeroOut      <= (w_result == '0);
      aluResultOut <= w_result;
      writeDataOut <= readData2;
      wrOut        <= regDst ? rd : rt;
      outCurrentPC <= inCurrentPC;
      branchTarget <= inCurrentPC + signExtImm[PC_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_ex.sv
`default_nettype none
// ============================================================================
// tb_stage_ex : self-checking bench for stage_ex (vector table + sequences)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_ex;

  logic        clk;
  logic        reset;
  logic        regWriteIn, memToRegIn, memWriteIn, branchIn;
  logic        aluSrc, regDst;
  logic [3:0]  aluCtrl;
  logic [31:0] readData1, readData2, signExtImm;
  logic [4:0]  rt, rd;
  logic [9:0]  inCurrentPC;
  logic        regWriteOut, memToRegOut, memWriteOut, branchOut, zeroOut;
  logic [31:0] aluResultOut, writeDataOut;
  logic [4:0]  wrOut;
  logic [9:0]  outCurrentPC, branchTarget;
  logic        stall;

  int nCompared = 0;
  int nMismatch = 0;

  stage_ex #(.DATA_W(32), .PC_W(10)) dut (
    .clk(clk), .reset(reset),
    .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
    .memWriteIn(memWriteIn), .branchIn(branchIn),
    .aluSrc(aluSrc), .regDst(regDst), .aluCtrl(aluCtrl),
    .readData1(readData1), .readData2(readData2), .signExtImm(signExtImm),
    .rt(rt), .rd(rd), .inCurrentPC(inCurrentPC),
    .regWriteOut(regWriteOut), .memToRegOut(memToRegOut),
    .memWriteOut(memWriteOut), .branchOut(branchOut), .zeroOut(zeroOut),
    .aluResultOut(aluResultOut), .writeDataOut(writeDataOut), .wrOut(wrOut),
    .outCurrentPC(outCurrentPC), .branchTarget(branchTarget), .stall(stall)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;   // {regWrite, memToReg, memWrite, branch}
    logic        src;
    logic        dst;
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic [4:0]  vRt, vRd;
    logic [9:0]  pc;
    logic [31:0] expRes;
    logic        expZero;
    logic [4:0]  expWr;
    logic [9:0]  expBt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ctrl, input logic src, input logic dst,
                       input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] vRt, input logic [4:0] vRd,
                       input logic [9:0] pc);
    {regWriteIn, memToRegIn, memWriteIn, branchIn} = ctrl;
    aluSrc = src; regDst = dst; aluCtrl = op;
    readData1 = a; readData2 = b; signExtImm = imm;
    rt = vRt; rd = vRd; inCurrentPC = pc;
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic checkAllZero(input string name);
    check({name, "_ctrl"}, {regWriteOut, memToRegOut, memWriteOut, branchOut}, 0);
    check({name, "_res"},  aluResultOut, 0);
    check({name, "_zero"}, zeroOut, 0);
    check({name, "_misc"}, {writeDataOut, wrOut, outCurrentPC, branchTarget}, 0);
  endtask

  // Presents a MUL/DIVU and walks it through its full 34-edge occupancy.
  task automatic runMulti(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expRes);
    int badStall = 0;
    int badBubble = 0;
    drive(4'b1000, 1'b0, 1'b1, op, a, b, 32'h0, 5'd0, 5'd5, 10'd7);
    for (int i = 1; i <= 33; i++) begin
      #1;
      if (stall !== 1'b1) badStall++;
      tick();
      if (regWriteOut !== 1'b0 || aluResultOut !== 32'h0 || zeroOut !== 1'b1 || wrOut !== 5'd0)
        badBubble++;
    end
    #1;
    check({name, "_stall_before_done"}, stall, 0);
    tick();
    check({name, "_stall_cycles_bad"}, badStall, 0);
    check({name, "_bubble_cycles_bad"}, badBubble, 0);
    check({name, "_result"}, aluResultOut, expRes);
    check({name, "_regWrite"}, regWriteOut, 1);
    check({name, "_wr"}, wrOut, 5);
  endtask

  initial begin
    //           ctrl     src   dst   op       a             b             imm           rt     rd     pc        expRes        z     wr     bt
    vecs[0] = '{4'b1000, 1'b1, 1'b1, 4'b0010, 32'd7,        32'h55,       32'hFFFFFFFD, 5'd4,  5'd9,  10'd5,    32'd4,        1'b0, 5'd9,  10'd2};
    vecs[1] = '{4'b0001, 1'b0, 1'b0, 4'b0110, 32'd5,        32'd5,        32'hFFFFFFFC, 5'd3,  5'd7,  10'd100,  32'd0,        1'b1, 5'd3,  10'd96};
    vecs[2] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 32'hF0F0,     32'hFF00,     32'd0,        5'd1,  5'd2,  10'd0,    32'hF000,     1'b0, 5'd2,  10'd0};
    vecs[3] = '{4'b1100, 1'b0, 1'b0, 4'b0001, 32'hF0F0,     32'h0F0F,     32'd10,       5'd6,  5'd8,  10'd20,   32'hFFFF,     1'b0, 5'd6,  10'd30};
    vecs[4] = '{4'b1000, 1'b0, 1'b1, 4'b1100, 32'd0,        32'd0,        32'd0,        5'd0,  5'd31, 10'd1023, 32'hFFFFFFFF, 1'b0, 5'd31, 10'd1023};
    vecs[5] = '{4'b1000, 1'b0, 1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        5'd0,  5'd10, 10'd1023, 32'd1,        1'b0, 5'd10, 10'd0};
    vecs[6] = '{4'b1000, 1'b0, 1'b1, 4'b0111, 32'd1,        32'hFFFFFFFF, 32'd0,        5'd0,  5'd10, 10'd50,   32'd0,        1'b1, 5'd10, 10'd50};
    vecs[7] = '{4'b1000, 1'b1, 1'b0, 4'b0010, 32'hFFFFFFFF, 32'h1234,     32'd1,        5'd12, 5'd13, 10'd10,   32'd0,        1'b1, 5'd12, 10'd11};
    vecs[8] = '{4'b0010, 1'b0, 1'b1, 4'b0011, 32'd5,        32'd6,        32'd0,        5'd2,  5'd3,  10'd0,    32'd0,        1'b1, 5'd3,  10'd0};
    vecs[9] = '{4'b1000, 1'b1, 1'b1, 4'b0110, 32'd3,        32'd77,       32'd5,        5'd0,  5'd17, 10'd200,  32'hFFFFFFFE, 1'b0, 5'd17, 10'd205};

    // Reset with every input nonzero, including a pending MUL.
    reset = 1'b1;
    drive(4'b1111, 1'b1, 1'b1, 4'b1000, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 10'd3);
    #1;
    check("reset_stall", stall, 0);
    tick();
    checkAllZero("reset");
    check("reset_stall_after_edge", stall, 0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].ctrl, vecs[k].src, vecs[k].dst, vecs[k].op, vecs[k].a, vecs[k].b,
            vecs[k].imm, vecs[k].vRt, vecs[k].vRd, vecs[k].pc);
      #1;
      check($sformatf("v%0d_stall", k), stall, 0);
      tick();
      check($sformatf("v%0d_res", k), aluResultOut, vecs[k].expRes);
      check($sformatf("v%0d_zero", k), zeroOut, vecs[k].expZero);
      check($sformatf("v%0d_wr", k), wrOut, vecs[k].expWr);
      check($sformatf("v%0d_bt", k), branchTarget, vecs[k].expBt);
      check($sformatf("v%0d_ctrl", k), {regWriteOut, memToRegOut, memWriteOut, branchOut}, vecs[k].ctrl);
      check($sformatf("v%0d_wdata", k), writeDataOut, vecs[k].b);
      check($sformatf("v%0d_pc", k), outCurrentPC, vecs[k].pc);
    end

    // Multi-cycle ops, issued back to back.
    runMulti("mul_16", 4'b1000, 32'h00010000, 32'h00010001, 32'h00010000);
    runMulti("divu_100_7", 4'b1001, 32'd100, 32'd7, 32'd14);
    runMulti("divu_by0", 4'b1001, 32'hDEADBEEF, 32'd0, 32'hFFFFFFFF);
    runMulti("mul_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
    runMulti("divu_max_10", 4'b1001, 32'hFFFFFFFF, 32'd10, 32'h19999999);

    // Abort a MUL with reset at BUSY step 10.
    drive(4'b1000, 1'b0, 1'b1, 4'b1000, 32'h00010000, 32'h00010001, 32'd0, 5'd0, 5'd5, 10'd7);
    repeat (11) tick();
    #1;
    check("abort_stall_busy", stall, 1);
    reset = 1'b1;
    #1;
    check("abort_stall_reset", stall, 0);
    tick();
    checkAllZero("abort");
    reset = 1'b0;
    drive(4'b1000, 1'b0, 1'b1, 4'b0010, 32'd7, 32'd3, 32'd0, 5'd0, 5'd9, 10'd40);
    #1;
    check("post_abort_stall", stall, 0);
    tick();
    check("post_abort_add", aluResultOut, 10);
    check("post_abort_wr", wrOut, 9);
    check("post_abort_regWrite", regWriteOut, 1);
    runMulti("mul_after_abort", 4'b1000, 32'd6, 32'd7, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
`default_nettype wire
